demux_stream_1to2: RTL and testbench
====================================

DEMUX_STREAM_1TO2 -- requirements
Module: demux_stream_1to2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per output FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have port d, input, WIDTH bits, input data word.
REQ-006 SHALL have port sel, input, 1 bit, destination select: 0 selects y0, 1 selects y1.
REQ-007 SHALL have port in_valid, input, 1 bit, d/sel valid.
REQ-008 SHALL have port in_ready, output, 1 bit, block can accept d.
REQ-009 SHALL have ports y0/y1, output, WIDTH bits each, head word of each output FIFO.
REQ-010 SHALL have ports y0_valid/y1_valid, output, 1 bit each, head word present.
REQ-011 SHALL have ports y0_ready/y1_ready, input, 1 bit each, consumer accepts head word.

Function
REQ-012 SHALL accept a word when in_valid && in_ready at a rising edge, then push {d} into FIFO[sel].
REQ-013 SHALL drive in_ready = !full[sel], combinational from sel and registered occupancy only; it SHALL NOT depend on y*_ready.
REQ-014 SHALL pop FIFO[n] when yn_valid && yn_ready at a rising edge.
REQ-015 SHALL have latency of exactly one cycle: a word accepted at edge N is visible on yn/yn_valid after edge N.
REQ-016 SHALL keep each output's state in EMPTY / PARTIAL / FULL, derived from the occupancy count 0..DEPTH: push-only increments, pop-only decrements, push+pop holds the count.
REQ-017 SHALL, when FIFO[n] is FULL, hold in_ready low for sel=n even if a pop occurs the same cycle; the pop SHALL still take effect.
REQ-018 SHALL, when FIFO[n] is EMPTY, drive yn_valid=0 and yn=0; a push into an empty FIFO is not forwarded in the same cycle.
REQ-019 SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL preserve arrival order within each output; the outputs are independent, and a stall on y1 SHALL NOT block traffic to y0.
REQ-021 SHALL ignore d and sel when in_valid=0.

Reset
REQ-022 SHALL, while rst=1 at an edge, clear pointers and counts, with in_ready=1, y0_valid=y1_valid=0 and y0=y1=0 after that edge.
REQ-023 SHALL discard all stored words on reset mid-operation; pushes and pops in the reset cycle SHALL be ignored.

Configuration
REQ-024 SHALL, with macro DEMUX_STREAM_CNT_EN defined, add outputs cnt0/cnt1, 16 bits each, counting pops per output; they reset to 0 and wrap from 0xFFFF to 0.
REQ-025 SHALL, without DEMUX_STREAM_CNT_EN, omit the cnt0/cnt1 ports and counter logic, with all other behaviour identical.

Structure
REQ-026 SHALL place the default WIDTH/DEPTH constants, the FIFO state encoding (EMPTY, PARTIAL, FULL) and the counter width 16 in shared package demux_pkg.
REQ-027 SHALL instantiate sub-module demux_fifo (one per output: push, pop, data, full, empty, count) twice.

Verification
REQ-028 Bench SHALL reset for 2 cycles -> in_ready=1, y0_valid=0, y1_valid=0, y0=0, y1=0.
REQ-029 Bench SHALL send d=0xA5 sel=0 then d=0x3C sel=1 with both ready=1 -> y0=0xA5 one cycle after its accept, y1=0x3C one cycle after its accept.
REQ-030 Bench SHALL hold y0_ready=0 and push 4 words with sel=0 -> in_ready=0 for sel=0 and in_ready=1 for sel=1; a y1 word still passes.
REQ-031 Bench SHALL, on a full FIFO0, drive y0_ready=1 and in_valid=1 sel=0 in the same cycle -> the pop occurs, the push is refused, and the count goes to 3.
REQ-032 Bench SHALL push 0x01, 0x02, 0x03 with sel=1 and assert rst mid-stream -> y1_valid=0 after reset, with no stale words emitted.
REQ-033 Bench SHALL, with DEMUX_STREAM_CNT_EN defined, make 3 pops on y0 and 1 on y1 -> cnt0=3, cnt1=1; with counters preloaded near 0xFFFF, the wrap reaches 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and FIFO state encoding for the 1-to-2 stream demux.
// DEMUX_STREAM_CNT_EN (in the top) enables the per-output pop counters sized by CNT_W.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO with occupancy-derived EMPTY/PARTIAL/FULL state; DEPTH is a power of two.
// A push while FULL is dropped; a pop while FULL still drains a word.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] cnt_q;
  logic [OCC_W-1:0] cnt_d;
  fifo_state_e      state_q;
  fifo_state_e      state_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (state_q != FIFO_FULL);
  assign pop_ok  = pop && (state_q != FIFO_EMPTY);

  // State, occupancy and pointer registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIFO_EMPTY;
      cnt_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= din;
  end

  // Next occupancy and the state it implies.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d == '0)                 state_d = FIFO_EMPTY;
    else if (cnt_d == OCC_W'(DEPTH)) state_d = FIFO_FULL;
    else                             state_d = FIFO_PARTIAL;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (state_q == FIFO_FULL);
  assign empty = (state_q == FIFO_EMPTY);
  assign count = cnt_q;

endmodule

// File: rtl/demux_stream_1to2.sv
// Routes an input stream to one of two independently back-pressured output FIFOs by sel.
// Define DEMUX_STREAM_CNT_EN to add 16-bit per-output pop counters cnt0/cnt1.
module demux_stream_1to2
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic [OCC_W-1:0] count0;
  logic [OCC_W-1:0] count1;
  logic [WIDTH-1:0] dout0;
  logic [WIDTH-1:0] dout1;
  logic             push0;
  logic             push1;
  logic             pop0;
  logic             pop1;

  // Acceptance looks only at the selected FIFO's registered fullness.
  assign in_ready = sel ? !full1 : !full0;
  assign push0    = in_valid && in_ready && !sel;
  assign push1    = in_valid && in_ready && sel;
  assign pop0     = y0_valid && y0_ready;
  assign pop1     = y1_valid && y1_ready;

  assign y0_valid = (count0 != '0);
  assign y1_valid = (count1 != '0);
  assign y0       = empty0 ? '0 : dout0;
  assign y1       = empty1 ? '0 : dout1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .din   (d),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0),
    .count (count0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .din   (d),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1),
    .count (count1)
  );

`ifdef DEMUX_STREAM_CNT_EN
  // Free-running pop counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + CNT_W'(1);
      if (pop1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_1to2.sv
// Directed bench for demux_stream_1to2: vector table plus hand-written reset, wrap and counter sequences.
// Counter checks are compiled in when DEMUX_STREAM_CNT_EN is defined.
module tb_demux_stream_1to2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'h00;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y0;
  logic       y0_valid;
  logic       y0_ready = 1'b0;
  logic [7:0] y1;
  logic       y1_valid;
  logic       y1_ready = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_stream_1to2 #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready)
`ifdef DEMUX_STREAM_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       chk_rdy;
    logic       rdy;
    logic       v0;
    logic [7:0] y0;
    logic       v1;
    logic [7:0] y1;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic iv, input logic s, input logic [7:0] dd,
                              input logic r0, input logic r1, input logic chk, input logic rdy,
                              input logic v0, input logic [7:0] e0, input logic v1, input logic [7:0] e1);
    vec_t v;
    v.rst = r; v.iv = iv; v.sel = s; v.d = dd; v.r0 = r0; v.r1 = r1;
    v.chk_rdy = chk; v.rdy = rdy; v.v0 = v0; v.y0 = e0; v.v1 = v1; v.y1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic s, input logic [7:0] dd,
                       input logic r0, input logic r1);
    rst = r; in_valid = iv; sel = s; d = dd; y0_ready = r0; y1_ready = r1;
  endtask

  task automatic cyc(input logic r, input logic iv, input logic s, input logic [7:0] dd,
                     input logic r0, input logic r1);
    drive(r, iv, s, dd, r0, r1);
    @(posedge clk);
    #1;
  endtask

  task automatic stream0(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'b1, 1'b0, 8'(j), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    //            rst iv sel d      r0 r1 chk rdy v0 y0     v1 y1
    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 1, 0, 8'hA5, 1, 1, 1, 1, 1, 8'hA5, 0, 8'h00);
    vecs[3]  = mk(0, 1, 1, 8'h3C, 1, 1, 1, 1, 0, 8'h00, 1, 8'h3C);
    vecs[4]  = mk(0, 0, 0, 8'hFF, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00);
    vecs[5]  = mk(0, 1, 0, 8'h11, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00);
    vecs[6]  = mk(0, 1, 0, 8'h22, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00);
    vecs[7]  = mk(0, 1, 0, 8'h33, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00);
    vecs[8]  = mk(0, 1, 0, 8'h44, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00);
    vecs[9]  = mk(0, 1, 0, 8'h55, 0, 1, 1, 0, 1, 8'h11, 0, 8'h00);
    vecs[10] = mk(0, 1, 1, 8'h66, 0, 1, 1, 1, 1, 8'h11, 1, 8'h66);
    vecs[11] = mk(0, 0, 1, 8'h99, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00);
    vecs[12] = mk(0, 1, 0, 8'h77, 1, 1, 1, 0, 1, 8'h22, 0, 8'h00);
    vecs[13] = mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h22, 0, 8'h00);
    vecs[14] = mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h33, 0, 8'h00);
    vecs[15] = mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h44, 0, 8'h00);
    vecs[16] = mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      if (vecs[i].chk_rdy) check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d y0_valid", i), 32'(y0_valid), 32'(vecs[i].v0));
      check($sformatf("v%0d y0", i), 32'(y0), 32'(vecs[i].y0));
      check($sformatf("v%0d y1_valid", i), 32'(y1_valid), 32'(vecs[i].v1));
      check($sformatf("v%0d y1", i), 32'(y1), 32'(vecs[i].y1));
    end

    // Reset in the middle of a stalled y1 stream, with a push and pop in the reset cycle.
    cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    check("rst_seq y1 first", 32'(y1), 32'h01);
    cyc(1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    check("rst_seq y1 head", 32'(y1), 32'h01);
    cyc(1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1);
    check("rst_seq y1_valid", 32'(y1_valid), 32'h0);
    check("rst_seq y1", 32'(y1), 32'h00);
    check("rst_seq y0_valid", 32'(y0_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    #1;
    check("rst_seq in_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      check($sformatf("rst_seq stale y1_valid c%0d", k), 32'(y1_valid), 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    check("post_rst y1", 32'(y1), 32'h5A);
    check("post_rst y1_valid", 32'(y1_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    check("post_rst drained", 32'(y1_valid), 32'h0);

    // Continuous push+pop on y0 across several pointer wraps.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(8'h80 + i), 1'b1, 1'b1);
      check($sformatf("wrap y0 w%0d", i), 32'(y0), 32'(8'h80 + i));
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("wrap drained", 32'(y0_valid), 32'h0);

`ifdef DEMUX_STREAM_CNT_EN
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("cnt0 reset", 32'(cnt0), 32'h0);
    check("cnt1 reset", 32'(cnt1), 32'h0);
    stream0(3);
    cyc(1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("cnt0 three pops", 32'(cnt0), 32'd3);
    check("cnt1 one pop", 32'(cnt1), 32'd1);
    stream0(65532);
    check("cnt0 at max", 32'(cnt0), 32'hFFFF);
    stream0(1);
    check("cnt0 wrapped", 32'(cnt0), 32'h0);
    check("cnt1 unchanged", 32'(cnt1), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
